// File: rtl/jtag_master_shift_if.sv
// Host-side command interface of the JTAG shift engine.
// The host drives a command strobe with its operands and watches busy/done/dout.
interface jtag_master_shift_if #(
   parameter int unsigned MAX_LEN = 32
);
   logic               start;
   logic [1:0]         cmd;
   logic [5:0]         len;
   logic [MAX_LEN-1:0] din;
   logic [MAX_LEN-1:0] dout;
   logic               busy;
   logic               done;

   modport master (
      output start, cmd, len, din,
      input  dout, busy, done
   );

   modport slave (
      input  start, cmd, len, din,
      output dout, busy, done
   );
endinterface

// File: rtl/jtag_master_shift.sv
// JTAG initiator: runs one host command (TAP reset, shift IR, shift DR or idle
// clocking) on TCK/TMS/TDI, captures TDO, and always leaves the TAP in
// Run-Test/Idle. TCK is derived from clk, CLK_DIV clk cycles per half period.
module jtag_master_shift #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   jtag_master_shift_if.slave  host,
   output logic                tck,
   output logic                tms,
   output logic                tdi,
   input  logic                tdo
);

   // Period index must reach the longest state (MAX_LEN shift bits or 6 reset periods).
   localparam int unsigned IW = ($clog2(MAX_LEN + 1) > 3) ? $clog2(MAX_LEN + 1) : 3;
   localparam int unsigned BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [1:0] CmdReset = 2'b00;
   localparam logic [1:0] CmdIr    = 2'b01;
   localparam logic [1:0] CmdDr    = 2'b10;
   localparam logic [1:0] CmdIdle  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StHead,
      StShift,
      StTail,
      StFin
   } state_e;

   state_e             state_q, state_d;
   logic [DW-1:0]      div_q, div_d;
   logic               tck_q, tck_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [1:0]         cmd_q, cmd_d;
   logic [IW-1:0]      len_q, len_d;
   logic [MAX_LEN-1:0] din_q, din_d;
   logic [MAX_LEN-1:0] dout_q, dout_d;
   logic [IW-1:0]      idx_nxt;
   state_e             nxt_st;

   // Number of TCK periods spent in a sequencing state for the latched command.
   function automatic logic [IW-1:0] num_periods(state_e st, logic [1:0] c, logic [IW-1:0] l);
      logic [IW-1:0] n;
      n = '0;
      case (st)
         StHead: begin
            case (c)
               CmdReset: n = IW'(6);
               CmdIr:    n = IW'(4);
               CmdDr:    n = IW'(3);
               default:  n = l;
            endcase
         end
         StShift: n = l;
         StTail:  n = IW'(2);
         default: n = '0;
      endcase
      return n;
   endfunction

   // TMS value for period i of a sequencing state.
   function automatic logic seq_tms(state_e st, logic [1:0] c, logic [IW-1:0] l,
                                    logic [IW-1:0] i);
      logic t;
      t = 1'b0;
      case (st)
         StHead: begin
            case (c)
               CmdReset: t = (i < IW'(5));
               CmdIr:    t = (i < IW'(2));
               CmdDr:    t = (i == '0);
               default:  t = 1'b0;
            endcase
         end
         StShift: t = (i == l - IW'(1));
         StTail:  t = (i == '0);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // State and datapath registers; reset parks the pins with TMS high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         div_q   <= '0;
         tck_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         idx_q   <= '0;
         cmd_q   <= '0;
         len_q   <= '0;
         din_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         idx_q   <= idx_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
      end
   end

   // Next-state logic: TCK phase counting, TMS/TDI sequencing and TDO capture.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tck_d   = tck_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      idx_d   = idx_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      din_d   = din_q;
      dout_d  = dout_q;
      idx_nxt = idx_q + IW'(1);
      nxt_st  = StFin;

      unique case (state_q)
         StIdle: begin
            tck_d = 1'b0;
            tdi_d = 1'b0;
            if (host.start) begin
               cmd_d   = host.cmd;
               len_d   = ({26'd0, host.len} > MAX_LEN) ? IW'(MAX_LEN) : IW'(host.len);
               din_d   = host.din;
               dout_d  = '0;
               state_d = StLoad;
            end
         end

         StLoad: begin
            div_d = '0;
            idx_d = '0;
            tck_d = 1'b0;
            tdi_d = 1'b0;
            // Zero-length shift or idle produces no TCK at all.
            if (cmd_q != CmdReset && len_q == '0) begin
               state_d = StFin;
               tms_d   = 1'b0;
            end else begin
               state_d = StHead;
               tms_d   = seq_tms(StHead, cmd_q, len_q, '0);
            end
         end

         StHead, StShift, StTail: begin
            if (div_q != DW'(CLK_DIV - 1)) begin
               div_d = div_q + DW'(1);
            end else begin
               div_d = '0;
               if (!tck_q) begin
                  // Rising TCK: target output is stable, capture it.
                  tck_d = 1'b1;
                  if (state_q == StShift) begin
                     dout_d[idx_q[BW-1:0]] = tdo;
                  end
               end else begin
                  // Falling TCK: the only point where TMS/TDI may move.
                  tck_d = 1'b0;
                  if (idx_nxt < num_periods(state_q, cmd_q, len_q)) begin
                     idx_d = idx_nxt;
                     tms_d = seq_tms(state_q, cmd_q, len_q, idx_nxt);
                     tdi_d = (state_q == StShift) ? din_q[idx_nxt[BW-1:0]] : 1'b0;
                  end else begin
                     case (state_q)
                        StHead:  nxt_st = (cmd_q == CmdIr || cmd_q == CmdDr) ? StShift : StFin;
                        StShift: nxt_st = StTail;
                        default: nxt_st = StFin;
                     endcase
                     idx_d   = '0;
                     state_d = nxt_st;
                     tms_d   = (nxt_st == StFin) ? 1'b0 : seq_tms(nxt_st, cmd_q, len_q, '0);
                     tdi_d   = (nxt_st == StShift) ? din_q[0] : 1'b0;
                  end
               end
            end
         end

         StFin: begin
            tck_d   = 1'b0;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;
   assign host.dout = dout_q;
   assign host.busy = (state_q == StLoad) || (state_q == StHead) ||
                      (state_q == StShift) || (state_q == StTail);
   assign host.done = (state_q == StFin);

endmodule

// File: tb/tb_jtag_master_shift.sv
// Bench for jtag_master_shift: builds the expected per-cycle pin trace of each
// command from the TMS/TDI sequence rules and the TCK period shape, and a
// single compare loop checks the DUT against it on every clk cycle.
module tb_jtag_master_shift;

   localparam int unsigned MAX_LEN = 32;
   localparam int unsigned CLK_DIV = 2;

   typedef struct packed {
      logic        tck;
      logic        tms;
      logic        tdi;
      logic        busy;
      logic        done;
      logic        chkd;
      logic [31:0] dout;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tck, tms, tdi, tdo;

   jtag_master_shift_if #(.MAX_LEN(MAX_LEN)) host ();

   jtag_master_shift #(
      .MAX_LEN (MAX_LEN),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (host),
      .tck   (tck),
      .tms   (tms),
      .tdi   (tdi),
      .tdo   (tdo)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic        model_tms = 1'b1;
   logic [31:0] model_dout = '0;
   logic        rise_tms[$];
   logic        rise_tdi[$];
   int          busy_cnt = 0;
   logic        tck_prev = 1'b0;

   // Target side: a per-period TDO pattern, advanced on every falling TCK.
   int          fall_cnt = 0;
   int          per_base = 0;
   logic [63:0] tdo_pat = '0;
   logic        loop = 1'b0;
   logic [5:0]  pidx;

   always @(negedge tck) fall_cnt = fall_cnt + 1;
   assign pidx = 6'(fall_cnt - per_base);
   assign tdo  = loop ? tdi : tdo_pat[pidx];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp = n_cmp + 1;
      if (got !== want) begin
         n_fail = n_fail + 1;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
      end
   endtask

   function automatic logic [63:0] pack(input logic q[$]);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
      return v;
   endfunction

   // The one compare process: every clk cycle, against the model trace or idle rules.
   task automatic compare_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            model_tms  = 1'b1;
            model_dout = '0;
         end else begin
            if (tck && !tck_prev) begin
               rise_tms.push_back(tms);
               rise_tdi.push_back(tdi);
            end
            if (host.busy) busy_cnt = busy_cnt + 1;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("pins tck/tms/tdi/busy/done", {27'd0, tck, tms, tdi, host.busy, host.done},
                     {27'd0, e.tck, e.tms, e.tdi, e.busy, e.done});
               if (e.chkd) check("dout", host.dout, e.dout);
               model_tms = e.tms;
               if (e.done) model_dout = e.dout;
            end else begin
               check("idle pins", {27'd0, tck, tms, tdi, host.busy, host.done},
                     {27'd0, 1'b0, model_tms, 1'b0, 1'b0, 1'b0});
               check("idle dout", host.dout, model_dout);
            end
         end
         tck_prev = tck;
      end
   endtask

   // Issue one command and queue its expected trace; optional stray start or abort.
   task automatic run_cmd(input logic [1:0] c, input logic [5:0] l, input logic [31:0] d,
                          input int mode, input int poke, input int abort_at);
      int          lc, h, np;
      logic        tq[$];
      logic        dq[$];
      logic [31:0] ed;
      exp_t        e;
      lc = (l > 6'd32) ? 32 : int'(l);
      h  = 0;
      if (c == 2'b00) begin
         for (int i = 0; i < 6; i++) tq.push_back(i < 5);
      end else if (c == 2'b11) begin
         for (int i = 0; i < lc; i++) tq.push_back(1'b0);
      end else if (lc > 0) begin
         h = (c == 2'b01) ? 4 : 3;
         tq.push_back(1'b1);
         if (c == 2'b01) tq.push_back(1'b1);
         tq.push_back(1'b0);
         tq.push_back(1'b0);
         for (int k = 0; k < lc; k++) tq.push_back(k == lc - 1);
         tq.push_back(1'b1);
         tq.push_back(1'b0);
      end
      np = tq.size();
      for (int p = 0; p < np; p++)
         dq.push_back(((c[1] ^ c[0]) && p >= h && p < h + lc) ? d[p-h] : 1'b0);

      tdo_pat = {$urandom, $urandom};
      loop    = (mode == 1);
      if (mode == 2) for (int k = 0; k < lc; k++) tdo_pat[h+k] = (k == 0);
      ed = '0;
      if (c[1] ^ c[0]) for (int k = 0; k < lc; k++) ed[k] = loop ? d[k] : tdo_pat[h+k];

      rise_tms.delete();
      rise_tdi.delete();
      busy_cnt = 0;
      @(posedge clk);
      #1;
      per_base   = fall_cnt;
      host.cmd   = c;
      host.len   = l;
      host.din   = d;
      host.start = 1'b1;
      @(posedge clk);
      #1;
      host.start = 1'b0;
      host.cmd   = 2'($urandom);
      host.len   = 6'($urandom);
      host.din   = $urandom;

      e = '0;
      e.tms  = model_tms;
      e.busy = 1'b1;
      e.chkd = 1'b1;
      exp_q.push_back(e);
      for (int p = 0; p < np; p++) begin
         for (int cc = 0; cc < 2 * CLK_DIV; cc++) begin
            e      = '0;
            e.tck  = (cc >= CLK_DIV);
            e.tms  = tq[p];
            e.tdi  = dq[p];
            e.busy = 1'b1;
            exp_q.push_back(e);
         end
      end
      e      = '0;
      e.done = 1'b1;
      e.chkd = 1'b1;
      e.dout = ed;
      exp_q.push_back(e);

      if (abort_at >= 0) begin
         repeat (abort_at) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check("abort pins", {27'd0, tck, tms, tdi, host.busy, host.done}, 32'h08);
         check("abort dout", host.dout, 32'h0);
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b1;
         return;
      end
      if (poke >= 0) begin
         repeat (poke) @(posedge clk);
         #1;
         host.start = 1'b1;
         host.cmd   = 2'b00;
         host.len   = 6'd9;
         @(posedge clk);
         #1;
         host.start = 1'b0;
      end
      for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_cmp  = n_cmp + 1;
         n_fail = n_fail + 1;
         $display("FAIL trace timeout: %0d expected cycles left", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
   endtask

   initial begin
      logic [31:0] r;
      host.start = 1'b0;
      host.cmd   = '0;
      host.len   = '0;
      host.din   = '0;
      fork
         compare_loop();
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("reset pins", {27'd0, tck, tms, tdi, host.busy, host.done}, 32'h08);
      check("reset dout", host.dout, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // TAP reset sequence.
      run_cmd(2'b00, 6'd0, 32'h0, 0, -1, -1);
      check("reset tck rises", rise_tms.size(), 32'd6);
      check("reset tms seq", 32'(pack(rise_tms)), 32'h1F);
      check("reset busy clks", busy_cnt, 32'd25);

      // Shift DR 8 bits, TDO looped back to TDI.
      run_cmd(2'b10, 6'd8, 32'hA5, 1, -1, -1);
      check("dr tck rises", rise_tms.size(), 32'd13);
      check("dr tms seq", 32'(pack(rise_tms)), 32'hC01);
      check("dr tdi bits", 32'((pack(rise_tdi) >> 3) & 64'hFF), 32'hA5);
      check("dr dout", host.dout, 32'hA5);

      // Shift IR 5 bits against a TAP returning capture 0x01.
      run_cmd(2'b01, 6'd5, 32'h1F, 2, -1, -1);
      check("ir tck rises", rise_tms.size(), 32'd11);
      check("ir head tms", 32'(pack(rise_tms) & 64'hF), 32'h3);
      check("ir dout", host.dout, 32'h01);

      // Zero-length shift: no TCK, busy only in LOAD.
      run_cmd(2'b10, 6'd0, 32'hFFFF_FFFF, 0, -1, -1);
      check("len0 tck rises", rise_tms.size(), 32'd0);
      check("len0 busy clks", busy_cnt, 32'd1);

      // Oversized length clamps to 32 bits.
      r = $urandom;
      run_cmd(2'b10, 6'd40, r, 1, -1, -1);
      check("len40 tck rises", rise_tms.size(), 32'd37);
      check("len40 dout", host.dout, r);

      // Stray start while busy, then one in the FIN cycle (1 + 9 periods * 4 clk).
      run_cmd(2'b10, 6'd6, 32'h2D, 0, 5, -1);
      run_cmd(2'b01, 6'd3, 32'h5, 0, 37, -1);

      // Random commands.
      for (int i = 0; i < 14; i++)
         run_cmd(2'($urandom), 6'($urandom_range(0, 45)), $urandom, int'($urandom % 2), -1, -1);

      // Abort in the middle of DR bit 3, then recover with a TAP reset.
      run_cmd(2'b10, 6'd8, 32'hC3, 0, -1, 26);
      repeat (2) @(posedge clk);
      run_cmd(2'b00, 6'd0, 32'h0, 0, -1, -1);
      check("post-abort reset rises", rise_tms.size(), 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jtag_master_shift.md
Name: jtag_master_shift

Overview:
- JTAG initiator for the TAP side of the project. It drives TCK/TMS/TDI toward a target TAP and samples its TDO.
- Executes single host commands: TAP reset, shift IR, shift DR, idle clocking. Every command ends with the TAP parked in Run-Test/Idle.
- Sits between a host/register interface and the external JTAG pins. The TCK it generates is divided down from the system clock.

Parameters:
- MAX_LEN, 32, maximum shift length in bits; width of din/dout.
- CLK_DIV, 2, clk cycles per TCK half-period (>=1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only when busy=0.
- cmd  in  2  00=RESET, 01=SHIFT_IR, 10=SHIFT_DR, 11=IDLE_CLK.
- len  in  6  bit count / idle TCK count.
- din  in  MAX_LEN  TDI data, LSB shifted first.
- dout  out  MAX_LEN  captured TDO data; bit i = i-th TDO bit.
- busy  out  1  command in progress.
- done  out  1  one-clk completion pulse.
- tck  out  1  JTAG test clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.

Behaviour:
- Reset (async, rst_n=0) sets: tck=0, tms=1, tdi=0, busy=0, done=0, dout=0, FSM=IDLE.
- Reset mid-command aborts immediately with no completion pulse. Target TAP state is then undefined; the host must issue RESET.
- FSM states: IDLE, LOAD, HEAD, SHIFT, TAIL, FIN.
- IDLE: start=1 latches cmd, len and din. Next clk goes to LOAD, busy=1. dout is cleared at LOAD.
- TCK period is 2*CLK_DIV clk: low half, then high half.
  - tck is always registered.
  - tms/tdi change only on the clk edge where tck falls (start of the low half).
  - tdo is sampled on the clk edge where tck rises.
- Each state consumes whole TCK periods. A command's first period begins the cycle after LOAD.
- TMS sequences:
  - RESET: tms = 1,1,1,1,1,0 (6 TCK). len ignored.
  - SHIFT_DR: HEAD tms = 1,0,0. SHIFT len periods, tms=0 except tms=1 on the last bit. TAIL tms = 1,0. Total len+5 TCK.
  - SHIFT_IR: HEAD tms = 1,1,0,0. SHIFT as for DR. TAIL tms = 1,0. Total len+6 TCK.
  - IDLE_CLK: len periods with tms=0.
- TDI: during SHIFT, bit k (0..len-1) = din[k]. Outside SHIFT, tdi=0.
- TDO capture: on the rising TCK of SHIFT bit k, dout[k] <= tdo. Bits >= len remain 0.
- len clamping:
  - len > MAX_LEN is clamped to MAX_LEN.
  - len=0 with SHIFT_* or IDLE_CLK: no TCK activity. FIN one clk after LOAD.
- FIN: done=1 for exactly one clk and busy=0 in the same cycle. tck=0 and tms=0 are held. Then return to IDLE.
- start while busy=1 is ignored; there is no queueing. start in the FIN cycle is also ignored.
- A new start is accepted the cycle after done, at the earliest.
- Between commands: tck=0, tms holds its last value, tdi=0.
- dout is stable from done until the next LOAD.

Test Plan:
- RESET, CLK_DIV=2: assert rst_n, then start cmd=00.
  - tms at each TCK rise = 1,1,1,1,1,0.
  - tck toggles every 2 clk.
  - done pulses after 24 clk of TCK activity; busy then low.
- SHIFT_DR len=8, din=0xA5, tdo tied to tdi.
  - tdi over the shift bits = 1,0,1,0,0,1,0,1.
  - tms=1 only on the 8th shift bit, then 1,0.
  - 13 TCK total; dout=0x000000A5.
- SHIFT_IR len=5, din=0x1F, tdo driven by a TAP model returning capture 0x01.
  - HEAD tms = 1,1,0,0.
  - dout=0x01 (low 5 bits), upper bits 0.
  - 11 TCK total.
- Boundaries:
  - len=0 SHIFT_DR: no tck edges, done 2 clk after start.
  - len=40: clamped to 32 shift bits, dout bits all valid.
  - start pulsed while busy: ignored, single done.
- Async reset mid-SHIFT_DR (bit 3): outputs go to reset values immediately, no done. A subsequent RESET command completes normally.
